// File: rtl/rwsp_ram_128x11.sv
// rwsp_ram_128x11
//   128 x 11 synchronous RAM, one write port, one read port, single clock.
//   The read path has two stages. The read address is registered on re.
//   The output data register then loads mem[ra_d] on ore. The FIFO
//   controlling this RAM issues re with the next address and pops with ore,
//   so dout holds steady while the consumer stalls.
//
// Ports
//   clk            rising-edge clock
//   reset          async, active-high; clears ra_d and dout_r only (mem kept)
//   pwrbus_ram_pd  power-down bus, no functional effect
//   wa / we / di   write address / write enable / write data
//   ra / re        read address / read-address capture enable
//   ore            output-register load enable
//   dout           registered read data
module rwsp_ram_128x11 #(
  parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pwrbus_ram_pd,
  input  logic [6:0]  wa,
  input  logic        we,
  input  logic [10:0] di,
  input  logic [6:0]  ra,
  input  logic        re,
  input  logic        ore,
  output logic [10:0] dout
);

  logic [10:0] mem [0:127];
  logic [6:0]  ra_d;
  logic [10:0] dout_ram;
  logic [10:0] dout_r;

  // The power bus only exists for port compatibility.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // No reset on storage. An unknown enable poisons the addressed entry so
  // that X on control lines is visible in simulation; in hardware the
  // second branch can never be taken.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= di;
    end else if (we !== 1'b0) begin
      mem[wa] <= 'x;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_d <= 7'd0;
    end else if (re) begin
      ra_d <= ra;
    end else if (re !== 1'b0) begin
      ra_d <= 'x;
    end
  end

  // Combinational array read. A write on the same edge as ore therefore
  // hands the pre-write contents to dout_r.
  assign dout_ram = mem[ra_d];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r <= 11'h000;
    end else if (ore) begin
      dout_r <= dout_ram;
    end else if (ore !== 1'b0) begin
      dout_r <= 'x;
    end
  end

  assign dout = dout_r;

  // Read/write contention on one address at the same edge. This is
  // simulation-only and has no functional effect.
  if (FORCE_CONTENTION_ASSERTION_RESET_ACTIVE == 1'b0) begin : g_contention
    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (!(we && re && (wa == ra)))
          else $error("rwsp_ram_128x11: read/write contention at address %0d", wa);
      end
    end
  end

endmodule

// File: tb/tb_rwsp_ram_128x11.sv
module tb_rwsp_ram_128x11;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pwrbus_ram_pd;
  logic [6:0]  wa;
  logic        we;
  logic [10:0] di;
  logic [6:0]  ra;
  logic        re;
  logic        ore;
  logic [10:0] dout;

  int n_checks = 0;
  int n_pass   = 0;

  rwsp_ram_128x11 dut (
    .clk           (clk),
    .reset         (reset),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .wa            (wa),
    .we            (we),
    .di            (di),
    .ra            (ra),
    .re            (re),
    .ore           (ore),
    .dout          (dout)
  );

  always #5 clk = ~clk;

  // Reference model: contents plus "written" flags, the captured read
  // address, and the value the consumer should currently see.
  logic [10:0] m_mem [0:127];
  bit          m_val [0:127];
  logic [6:0]  m_addr;
  logic [10:0] m_dout;
  bit          m_known;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: dout=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs, let the edge happen, then advance the model.
  // The model reads the old contents before applying the write, which gives
  // the pre-write value on a same-edge write/load.
  task automatic step(input logic we_i, input logic [6:0] wa_i, input logic [10:0] di_i,
                      input logic re_i, input logic [6:0] ra_i, input logic ore_i);
    logic [10:0] nd;
    bit          nk;
    we = we_i; wa = wa_i; di = di_i; re = re_i; ra = ra_i; ore = ore_i;
    pwrbus_ram_pd = $urandom;
    @(posedge clk);
    nd = m_dout;
    nk = m_known;
    if (ore_i) begin
      nd = m_mem[m_addr];
      nk = m_val[m_addr];
    end
    if (re_i) m_addr = ra_i;
    if (we_i) begin
      m_mem[wa_i] = di_i;
      m_val[wa_i] = 1'b1;
    end
    m_dout  = nd;
    m_known = nk;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any edge.
  task automatic pulse_reset(input string name);
    we = 1'b0; re = 1'b0; ore = 1'b0;
    #2 reset = 1'b1;
    #1;
    check(name, dout, 11'h000);
    m_addr  = 7'd0;
    m_dout  = 11'h000;
    m_known = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_known) check("model", dout, m_dout);
    end
  end

  initial begin
    reset = 1'b1;
    we = 1'b0; wa = '0; di = '0; re = 1'b0; ra = '0; ore = 1'b0;
    pwrbus_ram_pd = $urandom;
    for (int i = 0; i < 128; i++) begin
      m_mem[i] = 11'h000;
      m_val[i] = 1'b0;
    end
    m_addr  = 7'd0;
    m_dout  = 11'h000;
    m_known = 1'b1;
    #1;
    check("reset_dout", dout, 11'h000);
    #20 reset = 1'b0;
    @(posedge clk);
    #1;

    // Write then two-stage read
    step(1'b1, 7'd5, 11'h2A5, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 11'h000, 1'b1, 7'd5, 1'b0);
    check("re_only_no_change", dout, 11'h000);
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("read_5", dout, 11'h2A5);
    repeat (3) idle();
    check("hold_no_ore", dout, 11'h2A5);

    // Reset with non-trivial state, then no ore keeps dout at zero
    pulse_reset("async_reset");
    repeat (3) idle();
    check("post_reset_hold", dout, 11'h000);
    step(1'b0, 7'd0, 11'h000, 1'b1, 7'd5, 1'b0);
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("mem_kept_over_reset", dout, 11'h2A5);

    // Streaming fill and read, including the 127 -> 0 wrap
    for (int a = 0; a < 128; a++) begin
      step(1'b1, 7'(a), 11'(a) ^ 11'h555, 1'b0, 7'd0, 1'b0);
    end
    for (int i = 0; i <= 128; i++) begin
      step(1'b0, 7'd0, 11'h000, 1'b1, 7'(i), (i > 0));
      if (i == 1)   check("stream_addr0", dout, 11'h555);
      if (i == 128) check("stream_addr127", dout, 11'h52A);
    end
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("stream_wrap0", dout, 11'h555);

    // Stall: two addresses queued, ore held low for three cycles
    step(1'b0, 7'd0, 11'h000, 1'b1, 7'd10, 1'b0);
    step(1'b0, 7'd0, 11'h000, 1'b1, 7'd11, 1'b0);
    idle();
    check("stall_hold", dout, 11'h555);
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("stall_release_B", dout, 11'h55E);
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("ore_reload_same", dout, 11'h55E);

    // Same-edge write and load returns the old contents
    step(1'b1, 7'd3, 11'h001, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 11'h000, 1'b1, 7'd3, 1'b0);
    step(1'b1, 7'd3, 11'h7FF, 1'b0, 7'd0, 1'b1);
    check("hazard_old", dout, 11'h001);
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("hazard_new", dout, 11'h7FF);

    // Reset between re and ore: ra_d returns to 0
    step(1'b1, 7'd0, 11'h123, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 11'h000, 1'b1, 7'd20, 1'b0);
    pulse_reset("mid_op_reset");
    step(1'b0, 7'd0, 11'h000, 1'b0, 7'd0, 1'b1);
    check("after_reset_mem0", dout, 11'h123);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
